// File: rtl/game_pkg.sv
// Shared game-wide constants: game_state encoding, update stage indices and the stage count.
package game_pkg;

   localparam int unsigned NUM_STAGES = 4;

   localparam logic [1:0] GS_IDLE = 2'd0;
   localparam logic [1:0] GS_PLAY = 2'd1;
   localparam logic [1:0] GS_OVER = 2'd2;

   localparam logic [1:0] STAGE_PHYS    = 2'd0;
   localparam logic [1:0] STAGE_COLL    = 2'd1;
   localparam logic [1:0] STAGE_SHIFT   = 2'd2;
   localparam logic [1:0] STAGE_TABLOID = 2'd3;

   function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [1:0] idx);
      logic [NUM_STAGES-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/stage_timer.sv
// Per-stage watchdog: counts cycles since start and flags expiry after TIMEOUT cycles.
module stage_timer #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;

   // cnt_q holds (edges since start - 1), so expiry lands on the TIMEOUT-th edge.
   assign expired = run_q && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      if (clear) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
      end else if (run_q && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/update_scheduler.sv
// Frame update sequencer: on each accepted frame tick, waits for blanking and walks the
// update stages in order with request/done handshakes and per-stage timeouts.
module update_scheduler #(
   parameter int unsigned TIMEOUT  = 1023,
   parameter int unsigned N_STAGES = game_pkg::NUM_STAGES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                in_blank,
   input  logic [1:0]          game_state,
   output logic [N_STAGES-1:0] stage_req,
   input  logic [N_STAGES-1:0] stage_done,
   output logic                busy,
   output logic [N_STAGES-1:0] timeout_err,
   output logic [7:0]          overrun_cnt,
   output logic [15:0]         frame_count
);

   import game_pkg::*;

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StWaitBlank = 3'd1;
   localparam logic [2:0] StIssue     = 3'd2;
   localparam logic [2:0] StWaitDone  = 3'd3;
   localparam logic [2:0] StFinish    = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [1:0]          stg_q, stg_d;
   logic [N_STAGES-1:0] req_q, req_d;
   logic                busy_q, busy_d;
   logic [N_STAGES-1:0] terr_q, terr_d;
   logic [7:0]          ovr_q, ovr_d;
   logic [15:0]         fcnt_q, fcnt_d;
   logic                tmr_start, tmr_clear, tmr_expired;

   stage_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_stage_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (tmr_start),
      .clear   (tmr_clear),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      stg_d     = stg_q;
      req_d     = req_q;
      busy_d    = busy_q;
      terr_d    = terr_q;
      ovr_d     = ovr_q;
      fcnt_d    = fcnt_q;
      tmr_start = 1'b0;
      tmr_clear = 1'b0;

      // Any tick outside IDLE is dropped, FINISH included.
      if (frame_tick && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end

      case (state_q)
         StIdle: begin
            if (frame_tick) begin
               state_d = StWaitBlank;
               busy_d  = 1'b1;
               stg_d   = STAGE_PHYS;
            end
         end
         StWaitBlank: begin
            if (in_blank) state_d = StIssue;
         end
         StIssue: begin
            if ((game_state == GS_PLAY) || (stg_q == STAGE_TABLOID)) begin
               req_d     = stage_onehot(stg_q);
               tmr_start = 1'b1;
               state_d   = StWaitDone;
            end else begin
               stg_d = stg_q + 2'd1;
            end
         end
         StWaitDone: begin
            // A done coinciding with expiry wins: completion, no flag.
            if (stage_done[stg_q] || tmr_expired) begin
               if (!stage_done[stg_q]) terr_d[stg_q] = 1'b1;
               req_d     = '0;
               tmr_clear = 1'b1;
               if (stg_q == STAGE_TABLOID) begin
                  state_d = StFinish;
               end else begin
                  stg_d   = stg_q + 2'd1;
                  state_d = StIssue;
               end
            end
         end
         StFinish: begin
            fcnt_d  = fcnt_q + 16'd1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         stg_q   <= STAGE_PHYS;
         req_q   <= '0;
         busy_q  <= 1'b0;
         terr_q  <= '0;
         ovr_q   <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         stg_q   <= stg_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
         ovr_q   <= ovr_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign stage_req   = req_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;
   assign overrun_cnt = ovr_q;
   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Randomized bench for update_scheduler, checked against a per-sequence timing model.
module tb_update_scheduler;

   localparam int TO = 15;
   localparam logic [1:0] PLAY = 2'd1;
   localparam logic [1:0] OVER = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        in_blank;
   logic [1:0]  game_state;
   logic [3:0]  stage_req;
   logic [3:0]  stage_done;
   logic        busy;
   logic [3:0]  timeout_err;
   logic [7:0]  overrun_cnt;
   logic [15:0] frame_count;

   update_scheduler #(
      .TIMEOUT  (TO),
      .N_STAGES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .in_blank    (in_blank),
      .game_state  (game_state),
      .stage_req   (stage_req),
      .stage_done  (stage_done),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun_cnt (overrun_cnt),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Done delay per stage, in cycles after request assertion; 0 means never answered.
   int d_cfg [4];

   // Expected sequence shape from the model.
   logic [15:0] e_reqs;
   logic [31:0] e_holds;
   logic [3:0]  e_new_terr;
   int          e_len, e_first;

   // Observed sequence shape.
   logic [15:0] o_reqs;
   logic [31:0] o_holds;
   int          o_first, o_busy, o_ticks, o_bad;
   bit          o_hung;

   // Running architectural state.
   logic [15:0] m_fcnt = '0;
   logic [3:0]  m_terr = '0;
   int          m_ovr  = 0;

   // Busy lasts: 1 blank-check cycle, b unblanked cycles, per stage either one skip cycle
   // or issue + hold, then one finish cycle.
   task automatic model_seq(input logic [1:0] gs, input int b);
      int h, skips;
      bit to;
      logic [3:0] oh;
      e_reqs = '0; e_holds = '0; e_new_terr = '0; e_len = 2 + b; e_first = 0; skips = 0;
      for (int s = 0; s < 4; s++) begin
         if ((gs != PLAY) && (s != 3)) begin
            e_len++;
            skips++;
         end else begin
            to = (d_cfg[s] == 0) || (d_cfg[s] > TO);
            h  = to ? TO : d_cfg[s];
            oh = '0;
            oh[s] = 1'b1;
            if (e_first == 0) e_first = 3 + b + skips;
            e_reqs  = {e_reqs[11:0], oh};
            e_holds = {e_holds[23:0], 8'(h)};
            e_len   = e_len + 1 + h;
            if (to) e_new_terr[s] = 1'b1;
         end
      end
   endtask

   // Starts at a negedge with the DUT idle; tmode 0: no extra ticks, 1: random, 2: every cycle.
   task automatic run_seq(input logic [1:0] gs, input int b, input bit noise, input int tmode);
      logic [3:0] cur, prev;
      int cnt, s;
      o_reqs = '0; o_holds = '0; o_first = 0; o_busy = 0; o_ticks = 0; o_bad = 0; o_hung = 1;
      prev = '0; cnt = 0;
      game_state = gs; in_blank = (b == 0); stage_done = '0; frame_tick = 1'b1;
      for (int cyc = 1; cyc <= e_len + 40; cyc++) begin
         @(negedge clk);
         cur = stage_req;
         if (busy) o_busy++;
         if ($countones(cur) > 1) o_bad++;
         if (cur != prev) begin
            if (prev != 0) o_holds = {o_holds[23:0], cnt[7:0]};
            if (cur != 0) begin
               o_reqs = {o_reqs[11:0], cur};
               if (o_first == 0) o_first = cyc;
            end
            cnt = 0;
         end
         if (cur != 0) cnt++;
         prev = cur;
         if (!busy && cyc >= 2) begin
            o_hung = 0;
            break;
         end
         s = 0;
         for (int i = 0; i < 4; i++) if (cur[i]) s = i;
         stage_done = noise ? (4'($urandom) & ~cur) : 4'b0;
         if ((cur != 0) && (d_cfg[s] != 0) && (cnt == d_cfg[s])) stage_done[s] = 1'b1;
         in_blank   = (cyc > b);
         frame_tick = (cyc <= e_len) && ((tmode == 2) || ((tmode == 1) && ($urandom_range(0, 3) == 0)));
         if (frame_tick) o_ticks++;
      end
      frame_tick = 1'b0; stage_done = '0; in_blank = 1'b1;
      m_fcnt = m_fcnt + 16'd1;
      m_terr = m_terr | e_new_terr;
      m_ovr  = (m_ovr + o_ticks > 255) ? 255 : m_ovr + o_ticks;
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_tick = 1'b1; in_blank = 1'b1; game_state = PLAY; stage_done = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (stage_req !== 4'b0) begin n_err++; $display("FAIL reset_req got %b want 0000", stage_req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (timeout_err !== 4'b0) begin n_err++; $display("FAIL reset_terr got %b want 0000", timeout_err); end
      n_cmp++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL reset_ovr got %0d want 0", overrun_cnt); end
      n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_fcnt got %0d want 0", frame_count); end
      rst = 1'b0; frame_tick = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_tick_ignored busy got %b want 0", busy); end
   endtask

   task automatic test_play_basic();
      d_cfg = '{3, 3, 3, 3};
      model_seq(PLAY, 0);
      run_seq(PLAY, 0, 1'b0, 0);
      n_cmp++; if (o_hung) begin n_err++; $display("FAIL basic_hang busy never dropped"); end
      n_cmp++; if (o_reqs !== e_reqs) begin n_err++; $display("FAIL basic_reqs got %h want %h", o_reqs, e_reqs); end
      n_cmp++; if (o_holds !== e_holds) begin n_err++; $display("FAIL basic_holds got %h want %h", o_holds, e_holds); end
      n_cmp++; if (o_first !== e_first) begin n_err++; $display("FAIL basic_first got %0d want %0d", o_first, e_first); end
      n_cmp++; if (o_busy !== e_len) begin n_err++; $display("FAIL basic_busy got %0d want %0d", o_busy, e_len); end
      n_cmp++; if (o_bad !== 0) begin n_err++; $display("FAIL basic_onehot got %0d want 0", o_bad); end
      n_cmp++; if (frame_count !== m_fcnt) begin n_err++; $display("FAIL basic_fcnt got %0d want %0d", frame_count, m_fcnt); end
      n_cmp++; if (timeout_err !== m_terr) begin n_err++; $display("FAIL basic_terr got %b want %b", timeout_err, m_terr); end
   endtask

   task automatic test_over();
      d_cfg = '{3, 3, 3, 3};
      model_seq(OVER, 0);
      run_seq(OVER, 0, 1'b0, 0);
      n_cmp++; if (o_reqs !== e_reqs) begin n_err++; $display("FAIL over_reqs got %h want %h", o_reqs, e_reqs); end
      n_cmp++; if (o_first !== e_first) begin n_err++; $display("FAIL over_first got %0d want %0d", o_first, e_first); end
      n_cmp++; if (o_busy !== e_len) begin n_err++; $display("FAIL over_busy got %0d want %0d", o_busy, e_len); end
      n_cmp++; if (frame_count !== m_fcnt) begin n_err++; $display("FAIL over_fcnt got %0d want %0d", frame_count, m_fcnt); end
   endtask

   // Stage 1 never answers; stage 3 answers on the very timeout cycle.
   task automatic test_timeout();
      d_cfg = '{3, 0, 3, TO};
      model_seq(PLAY, 0);
      run_seq(PLAY, 0, 1'b0, 0);
      n_cmp++; if (o_reqs !== e_reqs) begin n_err++; $display("FAIL tmo_reqs got %h want %h", o_reqs, e_reqs); end
      n_cmp++; if (o_holds !== e_holds) begin n_err++; $display("FAIL tmo_holds got %h want %h", o_holds, e_holds); end
      n_cmp++; if (o_busy !== e_len) begin n_err++; $display("FAIL tmo_busy got %0d want %0d", o_busy, e_len); end
      n_cmp++; if (timeout_err !== m_terr) begin n_err++; $display("FAIL tmo_terr got %b want %b", timeout_err, m_terr); end
   endtask

   task automatic test_blank_wait();
      d_cfg = '{2, 2, 2, 2};
      model_seq(PLAY, 50);
      run_seq(PLAY, 50, 1'b0, 0);
      n_cmp++; if (o_first !== e_first) begin n_err++; $display("FAIL blank_first got %0d want %0d", o_first, e_first); end
      n_cmp++; if (o_reqs !== e_reqs) begin n_err++; $display("FAIL blank_reqs got %h want %h", o_reqs, e_reqs); end
      n_cmp++; if (o_busy !== e_len) begin n_err++; $display("FAIL blank_busy got %0d want %0d", o_busy, e_len); end
   endtask

   task automatic test_random();
      logic [1:0] gs;
      int b, tm;
      for (int it = 0; it < 20; it++) begin
         gs = 2'($urandom_range(0, 3));
         b  = $urandom_range(0, 5);
         tm = $urandom_range(0, 1);
         for (int s = 0; s < 4; s++) d_cfg[s] = $urandom_range(0, 18);
         model_seq(gs, b);
         run_seq(gs, b, 1'b1, tm);
         n_cmp++; if (o_reqs !== e_reqs) begin n_err++; $display("FAIL rnd%0d_reqs got %h want %h", it, o_reqs, e_reqs); end
         n_cmp++; if (o_holds !== e_holds) begin n_err++; $display("FAIL rnd%0d_holds got %h want %h", it, o_holds, e_holds); end
         n_cmp++; if (o_first !== e_first) begin n_err++; $display("FAIL rnd%0d_first got %0d want %0d", it, o_first, e_first); end
         n_cmp++; if (o_busy !== e_len) begin n_err++; $display("FAIL rnd%0d_busy got %0d want %0d", it, o_busy, e_len); end
         n_cmp++; if (o_bad !== 0) begin n_err++; $display("FAIL rnd%0d_onehot got %0d want 0", it, o_bad); end
         n_cmp++; if (timeout_err !== m_terr) begin n_err++; $display("FAIL rnd%0d_terr got %b want %b", it, timeout_err, m_terr); end
         n_cmp++; if (overrun_cnt !== 8'(m_ovr)) begin n_err++; $display("FAIL rnd%0d_ovr got %0d want %0d", it, overrun_cnt, m_ovr); end
         n_cmp++; if (frame_count !== m_fcnt) begin n_err++; $display("FAIL rnd%0d_fcnt got %0d want %0d", it, frame_count, m_fcnt); end
      end
   endtask

   // Five all-timeout sequences with a tick on every busy cycle push well past 300 drops.
   task automatic test_overrun();
      int total;
      total = 0;
      d_cfg = '{0, 0, 0, 0};
      for (int k = 0; k < 5; k++) begin
         model_seq(PLAY, 0);
         run_seq(PLAY, 0, 1'b0, 2);
         total += o_ticks;
         n_cmp++; if (overrun_cnt !== 8'(m_ovr)) begin n_err++; $display("FAIL ovr%0d got %0d want %0d", k, overrun_cnt, m_ovr); end
      end
      n_cmp++; if (total < 300) begin n_err++; $display("FAIL ovr_ticks got %0d want >=300", total); end
      n_cmp++; if (frame_count !== m_fcnt) begin n_err++; $display("FAIL ovr_fcnt got %0d want %0d", frame_count, m_fcnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_idle busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 0;
      game_state = PLAY; in_blank = 1'b1; stage_done = '0; frame_tick = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         if (stage_req == 4'b0100) begin
            seen = 1;
            break;
         end
         stage_done = stage_req;
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_reach stage 2 req not seen, req=%b", stage_req); end
      rst = 1'b1; frame_tick = 1'b1; stage_done = '0;
      @(negedge clk);
      m_fcnt = '0; m_terr = '0; m_ovr = 0;
      n_cmp++; if (stage_req !== 4'b0) begin n_err++; $display("FAIL rstmid_req got %b want 0000", stage_req); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if ({timeout_err, overrun_cnt} !== 12'd0) begin n_err++; $display("FAIL rstmid_flags got %h want 000", {timeout_err, overrun_cnt}); end
      n_cmp++; if (frame_count !== m_fcnt) begin n_err++; $display("FAIL rstmid_fcnt got %0d want %0d", frame_count, m_fcnt); end
      rst = 1'b0; frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, stage_req} !== 5'd0) begin n_err++; $display("FAIL rstmid_after got %b want 00000", {busy, stage_req}); end
      n_cmp++; if (frame_count !== m_fcnt) begin n_err++; $display("FAIL rstmid_fcnt_after got %0d want %0d", frame_count, m_fcnt); end
   endtask

   initial begin
      test_reset();
      test_play_basic();
      test_over();
      test_timeout();
      test_blank_wait();
      test_random();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/update_scheduler.md
UPDATE_SCHEDULER -- requirements
Module: update_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the maximum cycles a stage may hold its request before the scheduler abandons it.
REQ-002 SHALL have parameter N_STAGES, default 4, meaning the number of sequenced update stages; fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port frame_tick, input, 1 bit: one-cycle strobe at FPS rate.
REQ-006 SHALL have port in_blank, input, 1 bit: high while the beam is outside the visible area.
REQ-007 SHALL have port game_state, input, 2 bits: current game state, encoded per the shared package.
REQ-008 SHALL have port stage_req, output, N_STAGES bits: one-hot request. Bit 0 is doodle physics, bit 1 collision, bit 2 platform shift, bit 3 tabloid.
REQ-009 SHALL have port stage_done, input, N_STAGES bits: completion strobes, one per stage.
REQ-010 SHALL have port busy, output, 1 bit: high from tick acceptance until the sequence ends.
REQ-011 SHALL have port timeout_err, output, N_STAGES bits: sticky per-stage timeout flags.
REQ-012 SHALL have port overrun_cnt, output, 8 bits: saturating count of dropped ticks.
REQ-013 SHALL have port frame_count, output, 16 bits: number of completed sequences.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT_BLANK, ISSUE, WAIT_DONE and FINISH.
REQ-015 SHALL, in IDLE, on frame_tick=1, go to WAIT_BLANK and assert busy from the next cycle.
REQ-016 SHALL, in WAIT_BLANK, move to ISSUE on the first cycle with in_blank=1; if in_blank is already 1, WAIT_BLANK lasts one cycle.
REQ-017 SHALL process stages strictly in order 0,1,2,3; the first stage_req is asserted 2 cycles after an accepted tick when in_blank=1.
REQ-018 SHALL skip stages 0-2 (no request issued) when game_state is not PLAY; stage 3 always runs.
REQ-019 SHALL hold the active stage_req bit high, with at most one bit set, until stage_done of that stage is sampled high; the bit deasserts on the following edge.
REQ-020 SHALL ignore stage_done bits of inactive stages.
REQ-021 SHALL issue the next stage's request on the cycle after the current request drops.
REQ-022 SHALL, if stage_done is not seen within TIMEOUT cycles of request assertion, drop the request, set timeout_err[stage], and continue with the next stage.
REQ-023 SHALL treat a stage_done arriving on the same cycle as the timeout as a completion; no flag is set.
REQ-024 SHALL, in FINISH, increment frame_count (wrapping 0xFFFF to 0), deassert busy, and return to IDLE in one cycle.
REQ-025 SHALL drop any frame_tick arriving while busy=1, including in FINISH, without queuing it, and increment overrun_cnt, saturating at 255.
REQ-026 SHALL NOT abort the running sequence when game_state changes mid-sequence; the skip decision for each stage uses game_state sampled at that stage's ISSUE cycle.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force the FSM to IDLE and clear stage_req, busy, timeout_err, overrun_cnt, frame_count and the timer to 0.
REQ-028 SHALL, when rst is asserted mid-sequence, drop stage_req on that same edge; the abandoned sequence does not count in frame_count.
REQ-029 SHALL ignore frame_tick during the rst cycle.

Structure
REQ-030 SHALL take the game_state encoding (IDLE=0, PLAY=1, OVER=2), the stage indices and N_STAGES from the shared package game_pkg.
REQ-031 SHALL implement the per-stage timeout counter as sub-module stage_timer (start, clear, expired outputs, TIMEOUT parameter).
REQ-032 SHALL register all outputs, with no combinational path from input to output.

Verification
REQ-033 SHALL cover: PLAY, in_blank=1, tick, each stage_done returned 3 cycles after its request -> stage_req sequence 0001, 0010, 0100, 1000; frame_count=1; busy drops after the last done.
REQ-034 SHALL cover: game_state=OVER, tick -> only stage_req=1000 issued; frame_count increments.
REQ-035 SHALL cover: TIMEOUT=15, stage 1 never returns done -> req drops 15 cycles after assertion; timeout_err=0010; stage 2 request follows on the next cycle.
REQ-036 SHALL cover: 300 ticks issued while busy -> overrun_cnt=255 (saturated); no extra sequences run.
REQ-037 SHALL cover: in_blank=0 for 50 cycles after the tick -> no request until in_blank rises; then stage_req=0001 on the next cycle.
REQ-038 SHALL cover: rst pulsed during stage 2 -> all outputs 0 on the next cycle; frame_count remains 0.
